// File: rtl/reg_share_ctrl.sv
// Round-robin lease controller for one shared load-enable register (enable high loads, low clears).
// Optional LEASE_EXTEND_EN lets a lone owner renew its lease without a release gap.
module reg_share_ctrl #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 5,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic                      reg_en,
   output logic [DATA_W-1:0]         reg_data,
   output logic                      busy,
   output logic [1:0]                dbg_state
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] LOAD    = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_INIT   = PTR_W'(NUM_REQ - 1);

   // Handshake: req is a level sampled only in IDLE; grant marks ownership,
   // done pulses once when the lease ends; the owner must hold req for the lease.

   logic [1:0]          state;
   logic [PTR_W-1:0]    ptr;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   data_q;

   logic [NUM_REQ-1:0]  owner_oh;
   logic                owner_req;
   logic                others_req;
   logic                lease;
   logic                pick_valid;
   logic [PTR_W-1:0]    pick;
   logic [PTR_W-1:0]    idx;
   logic [DATA_W-1:0]   pick_data;

   // ptr doubles as the owner index: it only moves on grant.
   always_comb begin
      owner_oh      = '0;
      owner_oh[ptr] = 1'b1;
   end

   assign owner_req  = |(req & owner_oh);
   assign others_req = |(req & ~owner_oh);

   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      idx        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!pick_valid && req[idx]) begin
            pick_valid = 1'b1;
            pick       = idx;
         end
      end
   end

   assign pick_data = req_data[int'(pick)*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         ptr    <= PTR_INIT;
         cnt    <= '0;
         data_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state  <= LOAD;
                  ptr    <= pick;
                  data_q <= pick_data;
                  cnt    <= CNT_RELOAD;
               end
            end
            LOAD: begin
               if (!owner_req || cnt == '0) begin
                  state <= RELEASE;
               end else begin
                  state <= HOLD;
                  cnt   <= cnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (!owner_req) begin
                  state <= RELEASE;
               end else if (cnt == '0) begin
`ifdef LEASE_EXTEND_EN
                  if (!others_req) begin
                     cnt <= CNT_RELOAD;
                  end else begin
                     state <= RELEASE;
                  end
`else
                  state <= RELEASE;
`endif
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RELEASE: begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode the registered state, so an async reset clears them at once.
   assign lease     = (state == LOAD) || (state == HOLD);
   assign reg_en    = lease;
   assign grant     = lease ? owner_oh : '0;
   assign reg_data  = lease ? data_q : '0;
   assign done      = (state == RELEASE) ? owner_oh : '0;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_reg_share_ctrl.sv
// Directed vector bench for reg_share_ctrl; models the shared register Q to check load/clear timing.
module tb_reg_share_ctrl;

   localparam int NUM_REQ     = 4;
   localparam int DATA_W      = 5;
   localparam int HOLD_CYCLES = 4;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        done;
   logic                      reg_en;
   logic [DATA_W-1:0]         reg_data;
   logic                      busy;
   logic [1:0]                dbg_state;

   reg_share_ctrl #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD_CYCLES)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
      .grant(grant), .done(done), .reg_en(reg_en), .reg_data(reg_data),
      .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // shared register model: enable high loads data, low clears
   logic [DATA_W-1:0] q_model = '0;
   always @(posedge clk) q_model <= reg_en ? reg_data : '0;

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic [19:0] data;
      logic [3:0]  grant;
      logic [3:0]  done;
      logic        en;
      logic [4:0]  rdata;
      logic        busy;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [19:0] pack(input logic [4:0] d0, input logic [4:0] d1,
                                        input logic [4:0] d2, input logic [4:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic void add(input logic r, input logic [3:0] rq, input logic [19:0] d,
                               input logic [3:0] g, input logic [3:0] dn, input logic [4:0] rd);
      vec_t v;
      v.rst_n = r;
      v.req   = rq;
      v.data  = d;
      v.grant = g;
      v.done  = dn;
      v.en    = (g != 4'd0);
      v.rdata = (g != 4'd0) ? rd : 5'd0;
      v.busy  = (g != 4'd0) || (dn != 4'd0);
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, i, act, exp);
      end
   endtask

   // driver: inputs change on the falling edge, outputs sampled 1 time unit later
   task automatic step(input logic r, input logic [3:0] rq, input logic [19:0] d);
      @(negedge clk);
      reset_n  = r;
      req      = rq;
      req_data = d;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [19:0] d1, dw, dc, da, df, de, dab;
      logic [3:0]  g, dn, rq;
      logic [4:0]  rd, prev_q;
      int          ph, o;

      reset_n  = 1'b0;
      req      = '0;
      req_data = '0;

      d1  = pack(5'h15, 5'h00, 5'h00, 5'h00);
      dw  = pack(5'h03, 5'h00, 5'h00, 5'h07);
      dc  = pack(5'h01, 5'h02, 5'h03, 5'h04);
      da  = pack(5'h01, 5'h0A, 5'h03, 5'h04);
      df  = pack(5'h01, 5'h1F, 5'h03, 5'h04);
      de  = pack(5'h00, 5'h00, 5'h11, 5'h00);
      dab = pack(5'h09, 5'h00, 5'h00, 5'h00);

      // reset state
      add(0, 4'h0, 20'h0, 4'h0, 4'h0, 5'h0);
      add(0, 4'h0, 20'h0, 4'h0, 4'h0, 5'h0);

      // single request, requester 0 wins first; req1 joins in the last cycle so no renewal
      add(1, 4'h1, d1, 4'h0, 4'h0, 5'h00);
      for (int c = 1; c <= 3; c++) add(1, 4'h1, d1, 4'h1, 4'h0, 5'h15);
      add(1, 4'h3, d1, 4'h1, 4'h0, 5'h15);
      add(1, 4'h0, d1, 4'h0, 4'h1, 5'h00);
      add(1, 4'h0, d1, 4'h0, 4'h0, 5'h00);
      add(1, 4'h0, d1, 4'h0, 4'h0, 5'h00);

      // wrap: grant 3, then 1001 goes to requester 0; non-owner never pre-empts
      add(1, 4'h8, dw, 4'h0, 4'h0, 5'h00);
      add(1, 4'h8, dw, 4'h8, 4'h0, 5'h07);
      for (int c = 2; c <= 4; c++) add(1, 4'h9, dw, 4'h8, 4'h0, 5'h07);
      add(1, 4'h9, dw, 4'h0, 4'h8, 5'h00);
      add(1, 4'h9, dw, 4'h0, 4'h0, 5'h00);
      for (int c = 7; c <= 10; c++) add(1, 4'h9, dw, 4'h1, 4'h0, 5'h03);
      add(1, 4'h0, dw, 4'h0, 4'h1, 5'h00);
      add(1, 4'h0, dw, 4'h0, 4'h0, 5'h00);

      // full contention: leases start at cycles 1,7,13,19,25
      add(0, 4'h0, dc, 4'h0, 4'h0, 5'h00);
      add(1, 4'hF, dc, 4'h0, 4'h0, 5'h00);
      for (int c = 1; c <= 26; c++) begin
         ph = (c - 1) % 6;
         o  = ((c - 1) / 6) % 4;
         g  = (ph < 4)  ? (4'h1 << o) : 4'h0;
         dn = (ph == 4) ? (4'h1 << o) : 4'h0;
         add(1, 4'hF, dc, g, dn, 5'(o + 1));
      end

      // reset mid-HOLD, then 0011 grants requester 0 first; data freeze on requester 1
      add(0, 4'hF, dc, 4'h0, 4'h0, 5'h00);
      add(1, 4'h3, dc, 4'h0, 4'h0, 5'h00);
      for (int c = 1; c <= 4; c++) add(1, 4'h3, dc, 4'h1, 4'h0, 5'h01);
      add(1, 4'h3, da, 4'h0, 4'h1, 5'h00);
      add(1, 4'h3, da, 4'h0, 4'h0, 5'h00);
      add(1, 4'h3, da, 4'h2, 4'h0, 5'h0A);
      for (int c = 2; c <= 4; c++) add(1, 4'h3, df, 4'h2, 4'h0, 5'h0A);
      add(1, 4'h0, df, 4'h0, 4'h2, 5'h00);
      add(1, 4'h0, df, 4'h0, 4'h0, 5'h00);

      // lone requester 2 held for cycles 0..13, dropped at 14
      add(0, 4'h0, de, 4'h0, 4'h0, 5'h00);
      add(1, 4'h4, de, 4'h0, 4'h0, 5'h00);
      for (int c = 1; c <= 16; c++) begin
         rq = (c <= 13) ? 4'h4 : 4'h0;
`ifdef LEASE_EXTEND_EN
         g  = (c <= 14) ? 4'h4 : 4'h0;
         dn = (c == 15) ? 4'h4 : 4'h0;
`else
         g  = ((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || c == 13 || c == 14) ? 4'h4 : 4'h0;
         dn = (c == 5 || c == 11 || c == 15) ? 4'h4 : 4'h0;
`endif
         add(1, rq, de, g, dn, 5'h11);
      end

      // apply the table
      prev_q = '0;
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst_n, vecs[i].req, vecs[i].data);
         check("grant",    i, 32'(grant),    32'(vecs[i].grant));
         check("done",     i, 32'(done),     32'(vecs[i].done));
         check("reg_en",   i, 32'(reg_en),   32'(vecs[i].en));
         check("reg_data", i, 32'(reg_data), 32'(vecs[i].rdata));
         check("busy",     i, 32'(busy),     32'(vecs[i].busy));
         check("reg_q",    i, 32'(q_model),  32'(prev_q));
         prev_q = vecs[i].en ? vecs[i].rdata : 5'h00;
      end

      // abort: owner drops req in the second lease cycle
      step(0, 4'h0, dab);
      step(1, 4'h1, dab);
      step(1, 4'h1, dab);
      check("abort_grant_c1", 1, 32'(grant),    32'h1);
      check("abort_data_c1",  1, 32'(reg_data), 32'h09);
      step(1, 4'h0, dab);
      check("abort_en_c2",    2, 32'(reg_en),   32'h1);
      step(1, 4'h0, dab);
      check("abort_done_c3",  3, 32'(done),     32'h1);
      check("abort_en_c3",    3, 32'(reg_en),   32'h0);
      check("abort_busy_c3",  3, 32'(busy),     32'h1);
      step(1, 4'h0, dab);
      check("abort_busy_c4",  4, 32'(busy),     32'h0);
      check("abort_done_c4",  4, 32'(done),     32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
